// File: rtl/axi4_sram_responder_pkg.sv
// Shared definitions for the AXI4 SRAM responder and related bus models.
// Contents: AXI response codes, read/write FSM state encodings, delay-LFSR width/taps.
// No ports; imported by axi4_lfsr_gate and axi4_sram_responder.
package axi4_sram_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // 20-bit Fibonacci LFSR; the MSB doubles as the stall gate bit.
   localparam int LFSR_W     = 20;
   localparam int LFSR_TAP_A = 19;
   localparam int LFSR_TAP_B = 18;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_DATA = 2'b01,
      W_RESP = 2'b10
   } wr_state_e;

endpackage

// File: rtl/axi4_lfsr_gate.sv
// Pseudo-random stall gate: 20-bit LFSR shifting every cycle, gate_o = EN ? msb : 1.
// Latency: gate_o is a registered bit, no input path. Backpressure: none (free-running).
// Ports: clk_i clock, rst_i async active-high reset (LFSR seeded to 1), gate_o stall gate.
module axi4_lfsr_gate
   import axi4_sram_responder_pkg::*;
#(
   parameter bit EN = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic gate_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_W'(1);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign gate_o = EN ? lfsr_q[LFSR_TAP_A] : 1'b1;

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 slave over an internal 64-bit SRAM; single-beat and INCR bursts, SLVERR outside the window.
// Latency: first R beat one cycle after the AR handshake, one beat per cycle after; B one cycle after last W.
// Backpressure: R/B held stable until rready/bready; optional LFSR gate stalls arready/awready/rvalid/bvalid.
// Ports: AR/R/AW/W/B channels as in AXI4 (no burst/size/prot fields), clk, rst async active-high.
module axi4_sram_responder
   import axi4_sram_responder_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter int               DEPTH    = 4096,
   parameter logic [ADDR_W-1:0] BASE    = 'h8000_0000,
   parameter bit               DELAY_EN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [3:0]        arid,
   input  logic              arvalid,
   output logic              arready_o,
   output logic [63:0]       rdata_o,
   output logic [3:0]        rid_o,
   output logic              rlast_o,
   output logic [1:0]        rresp_o,
   output logic              rvalid_o,
   input  logic              rready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic [3:0]        awid,
   input  logic              awvalid,
   output logic              awready_o,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready_o,
   output logic [3:0]        bid_o,
   output logic [1:0]        bresp_o,
   output logic              bvalid_o,
   input  logic              bready
);

   localparam int IDX_W = $clog2(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= BASE) && (((a - BASE) >> (IDX_W + 3)) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE) >> 3);
   endfunction

   logic gate;
   logic active_q;
   logic [63:0] mem_q [DEPTH];

   axi4_lfsr_gate #(.EN(DELAY_EN)) u_gate (
      .clk_i  (clk),
      .rst_i  (rst),
      .gate_o (gate)
   );

   // Holds the address-channel readies low while reset is applied and for the first edge after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) active_q <= 1'b0;
      else     active_q <= 1'b1;
   end

   // ---------------- read channel ----------------
   rd_state_e         rd_state_q, rd_state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [3:0]        rid_q, rid_d;
   logic              rhold_q, rhold_d;   // rvalid already shown; keep it up despite the gate
   logic              fetch;
   logic [ADDR_W-1:0] fetch_addr;
   logic [63:0]       rdata_q;
   logic [1:0]        rresp_q;

   always_comb begin
      rd_state_d = rd_state_q;
      raddr_d    = raddr_q;
      rlen_d     = rlen_q;
      rbeat_d    = rbeat_q;
      rid_d      = rid_q;
      rhold_d    = rhold_q;
      arready_o  = 1'b0;
      rvalid_o   = 1'b0;
      fetch      = 1'b0;
      fetch_addr = araddr;
      case (rd_state_q)
         R_IDLE: begin
            arready_o = active_q & gate;
            if (arvalid && arready_o) begin
               raddr_d    = araddr;
               rlen_d     = arlen;
               rid_d      = arid;
               rbeat_d    = '0;
               rhold_d    = 1'b0;
               fetch      = 1'b1;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            rvalid_o = gate | rhold_q;
            if (rvalid_o && rready) begin
               rhold_d = 1'b0;
               if (rbeat_q == rlen_q) begin
                  rd_state_d = R_IDLE;
               end else begin
                  // Prefetch the next beat on the handshake edge so it is valid next cycle.
                  rbeat_d    = rbeat_q + 8'd1;
                  raddr_d    = raddr_q + ADDR_W'(8);
                  fetch      = 1'b1;
                  fetch_addr = raddr_d;
               end
            end else if (rvalid_o) begin
               rhold_d = 1'b1;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rbeat_q    <= '0;
         rid_q      <= '0;
         rhold_q    <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rbeat_q    <= rbeat_d;
         rid_q      <= rid_d;
         rhold_q    <= rhold_d;
      end
   end

   // Registered SRAM read port; a same-edge write to this word lands after the read samples it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (fetch) begin
         if (in_range(fetch_addr)) begin
            rdata_q <= mem_q[word_idx(fetch_addr)];
            rresp_q <= RESP_OKAY;
         end else begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign rresp_o = rresp_q;
   assign rid_o   = rid_q;
   assign rlast_o = (rd_state_q == R_DATA) && (rbeat_q == rlen_q);

   // ---------------- write channel ----------------
   wr_state_e         wr_state_q, wr_state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [3:0]        bid_q, bid_d;
   logic              werr_q, werr_d;
   logic              bhold_q, bhold_d;
   logic              mem_we;

   always_comb begin
      wr_state_d = wr_state_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wbeat_d    = wbeat_q;
      bid_d      = bid_q;
      werr_d     = werr_q;
      bhold_d    = bhold_q;
      awready_o  = 1'b0;
      wready_o   = 1'b0;
      bvalid_o   = 1'b0;
      mem_we     = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            awready_o = active_q & gate;
            if (awvalid && awready_o) begin
               waddr_d    = awaddr;
               wlen_d     = awlen;
               bid_d      = awid;
               wbeat_d    = '0;
               werr_d     = 1'b0;
               bhold_d    = 1'b0;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            wready_o = 1'b1;
            if (wvalid) begin
               if (in_range(waddr_q)) mem_we = 1'b1;
               else                   werr_d = 1'b1;
               // The beat count, not wlast, ends the burst; a misplaced wlast only flags an error.
               if (wlast != (wbeat_q == wlen_q)) werr_d = 1'b1;
               if (wbeat_q == wlen_q) begin
                  wr_state_d = W_RESP;
               end else begin
                  wbeat_d = wbeat_q + 8'd1;
                  waddr_d = waddr_q + ADDR_W'(8);
               end
            end
         end
         W_RESP: begin
            bvalid_o = gate | bhold_q;
            if (bvalid_o && bready) begin
               bhold_d    = 1'b0;
               wr_state_d = W_IDLE;
            end else if (bvalid_o) begin
               bhold_d = 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wbeat_q    <= '0;
         bid_q      <= '0;
         werr_q     <= 1'b0;
         bhold_q    <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wbeat_q    <= wbeat_d;
         bid_q      <= bid_d;
         werr_q     <= werr_d;
         bhold_q    <= bhold_d;
      end
   end

   // SRAM array is not reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign bid_o   = bid_q;
   assign bresp_o = werr_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_sram_responder.sv
module tb_axi4_sram_responder;

   logic clk, rst, d_rst;
   int total, bad;

   // main DUT, no stall injection
   logic [31:0] araddr, awaddr;
   logic [7:0]  arlen, awlen, wstrb;
   logic [3:0]  arid, awid, rid_o, bid_o;
   logic        arvalid, arready_o, rlast_o, rvalid_o, rready;
   logic        awvalid, awready_o, wlast, wvalid, wready_o, bvalid_o, bready;
   logic [63:0] rdata_o, wdata;
   logic [1:0]  rresp_o, bresp_o;

   // second DUT with the LFSR gate enabled; write channel tied idle
   logic [31:0] d_araddr;
   logic [7:0]  d_arlen;
   logic [3:0]  d_arid, d_rid_o, d_bid_o;
   logic        d_arvalid, d_arready_o, d_rlast_o, d_rvalid_o, d_rready;
   logic        d_awready_o, d_wready_o, d_bvalid_o;
   logic [63:0] d_rdata_o;
   logic [1:0]  d_rresp_o, d_bresp_o;

   axi4_sram_responder dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arlen(arlen), .arid(arid), .arvalid(arvalid), .arready_o(arready_o),
      .rdata_o(rdata_o), .rid_o(rid_o), .rlast_o(rlast_o), .rresp_o(rresp_o),
      .rvalid_o(rvalid_o), .rready(rready),
      .awaddr(awaddr), .awlen(awlen), .awid(awid), .awvalid(awvalid), .awready_o(awready_o),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
   );

   axi4_sram_responder #(.DELAY_EN(1'b1)) dut_dly (
      .clk(clk), .rst(d_rst),
      .araddr(d_araddr), .arlen(d_arlen), .arid(d_arid), .arvalid(d_arvalid), .arready_o(d_arready_o),
      .rdata_o(d_rdata_o), .rid_o(d_rid_o), .rlast_o(d_rlast_o), .rresp_o(d_rresp_o),
      .rvalid_o(d_rvalid_o), .rready(d_rready),
      .awaddr(32'h0), .awlen(8'h0), .awid(4'h0), .awvalid(1'b0), .awready_o(d_awready_o),
      .wdata(64'h0), .wstrb(8'h0), .wlast(1'b0), .wvalid(1'b0), .wready_o(d_wready_o),
      .bid_o(d_bid_o), .bresp_o(d_bresp_o), .bvalid_o(d_bvalid_o), .bready(1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driving helpers (no checking) ----------------
   task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id, output bit ok);
      int n = 0;
      araddr = a; arlen = l; arid = id; arvalid = 1'b1;
      while (!arready_o && n < 50) begin @(posedge clk); #1; n++; end
      ok = arready_o;
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id, output bit ok);
      int n = 0;
      awaddr = a; awlen = l; awid = id; awvalid = 1'b1;
      while (!awready_o && n < 50) begin @(posedge clk); #1; n++; end
      ok = awready_o;
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last, output bit ok);
      int n = 0;
      wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
      while (!wready_o && n < 50) begin @(posedge clk); #1; n++; end
      ok = wready_o;
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic b_take(output logic [1:0] rs, output logic [3:0] id, output bit ok);
      int n = 0;
      bready = 1'b1;
      while (!bvalid_o && n < 50) begin @(posedge clk); #1; n++; end
      ok = bvalid_o; rs = bresp_o; id = bid_o;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic r_take(output logic [63:0] d, output logic [1:0] rs, output logic l,
                         output logic [3:0] id, output bit ok);
      int n = 0;
      rready = 1'b1;
      while (!rvalid_o && n < 50) begin @(posedge clk); #1; n++; end
      ok = rvalid_o; d = rdata_o; rs = rresp_o; l = rlast_o; id = rid_o;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({arready_o, awready_o, wready_o, rvalid_o, bvalid_o, rlast_o, rresp_o, bresp_o,
           rid_o, bid_o, rdata_o} !== '0) begin
         bad++; $display("FAIL reset_outputs: rvalid=%b arready=%b rdata=%h want all zero",
                         rvalid_o, arready_o, rdata_o);
      end
      total++;
      if ({d_arready_o, d_awready_o, d_wready_o, d_rvalid_o, d_bvalid_o, d_rlast_o, d_rresp_o,
           d_bresp_o, d_rid_o, d_bid_o, d_rdata_o} !== '0) begin
         bad++; $display("FAIL reset_outputs_dly: rvalid=%b rdata=%h want all zero", d_rvalid_o, d_rdata_o);
      end
      rst = 1'b0; d_rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({arready_o, awready_o} !== 2'b11) begin
         bad++; $display("FAIL reset_release_ready: got %b%b want 11", arready_o, awready_o);
      end
   endtask

   task automatic test_single();
      bit ok, o; logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
      total++;
      if (wready_o !== 1'b0) begin bad++; $display("FAIL wready_idle: got %b want 0", wready_o); end
      aw_send(32'h8000_0008, 8'd0, 4'd3, ok);
      w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1, o); ok &= o;
      b_take(rs, id, o); ok &= o;
      total++; if (rs !== 2'b00) begin bad++; $display("FAIL single_bresp: got %b want 00", rs); end
      total++; if (id !== 4'd3) begin bad++; $display("FAIL single_bid: got %h want 3", id); end
      ar_send(32'h8000_0008, 8'd0, 4'd5, o); ok &= o;
      total++;
      if (rvalid_o !== 1'b1) begin bad++; $display("FAIL single_rlatency: rvalid %b want 1", rvalid_o); end
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if (d !== 64'h1122_3344_5566_7788) begin
         bad++; $display("FAIL single_rdata: got %h want 1122334455667788", d);
      end
      total++;
      if ({l, rs, id} !== {1'b1, 2'b00, 4'd5}) begin
         bad++; $display("FAIL single_rattr: last=%b resp=%b id=%h want 1 00 5", l, rs, id);
      end
      total++; if (!ok) begin bad++; $display("FAIL single_handshake: timeout got 0 want 1"); end
   endtask

   task automatic test_partial();
      bit ok, o; logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
      aw_send(32'h8000_0008, 8'd0, 4'd1, ok);
      w_beat(64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1, o); ok &= o;
      b_take(rs, id, o); ok &= o;
      ar_send(32'h8000_0008, 8'd0, 4'd2, o); ok &= o;
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if (d !== 64'h1122_3344_BBBB_BBBB) begin
         bad++; $display("FAIL partial_rdata: got %h want 11223344BBBBBBBB", d);
      end
      total++; if (!ok) begin bad++; $display("FAIL partial_handshake: timeout got 0 want 1"); end
   endtask

   task automatic test_burst();
      bit ok, o, prev_stall, rr; int k;
      logic [63:0] held; logic [1:0] rs; logic [3:0] id;
      logic [63:0] bd [4];
      bd = '{64'h1000_0000_0000_00A0, 64'h2000_0000_0000_00B1,
             64'h3000_0000_0000_00C2, 64'h4000_0000_0000_00D3};
      aw_send(32'h8000_0100, 8'd3, 4'd1, ok);
      for (int i = 0; i < 4; i++) begin w_beat(bd[i], 8'hFF, i == 3, o); ok &= o; end
      b_take(rs, id, o); ok &= o;
      total++; if (rs !== 2'b00) begin bad++; $display("FAIL burst_bresp: got %b want 00", rs); end
      ar_send(32'h8000_0100, 8'd3, 4'd2, o); ok &= o;
      k = 0; rr = 1'b1; prev_stall = 1'b0; held = '0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         rready = rr;
         if (rvalid_o) begin
            if (prev_stall) begin
               total++;
               if (rdata_o !== held) begin
                  bad++; $display("FAIL burst_stable: got %h want %h", rdata_o, held);
               end
            end
            if (rr) begin
               total++;
               if (rdata_o !== bd[k]) begin
                  bad++; $display("FAIL burst_beat%0d: got %h want %h", k, rdata_o, bd[k]);
               end
               total++;
               if (rlast_o !== (k == 3)) begin
                  bad++; $display("FAIL burst_rlast%0d: got %b want %b", k, rlast_o, k == 3);
               end
               k++; prev_stall = 1'b0;
            end else begin
               held = rdata_o; prev_stall = 1'b1;
            end
         end
         rr = !rr;
         @(posedge clk); #1;
      end
      rready = 1'b0;
      total++; if (k != 4) begin bad++; $display("FAIL burst_count: got %0d want 4", k); end
      total++; if (!ok) begin bad++; $display("FAIL burst_handshake: timeout got 0 want 1"); end
   endtask

   task automatic test_out_of_range();
      bit ok, o; logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id;
      aw_send(32'h8000_0000, 8'd0, 4'd1, ok);
      w_beat(64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 1'b1, o); ok &= o;
      b_take(rs, id, o); ok &= o;
      aw_send(32'h8000_8000, 8'd0, 4'd2, o); ok &= o;
      w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, o); ok &= o;
      b_take(rs, id, o); ok &= o;
      total++; if (rs !== 2'b10) begin bad++; $display("FAIL oor_bresp: got %b want 10", rs); end
      ar_send(32'h7FFF_FFF8, 8'd0, 4'd4, o); ok &= o;
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if ({rs, d} !== {2'b10, 64'h0}) begin
         bad++; $display("FAIL oor_read: resp=%b data=%h want 10 0", rs, d);
      end
      ar_send(32'h8000_0000, 8'd0, 4'd4, o); ok &= o;
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if (d !== 64'h0F0F_0F0F_0F0F_0F0F) begin
         bad++; $display("FAIL oor_mem_kept: got %h want 0f0f0f0f0f0f0f0f", d);
      end
      // two-beat burst straddling the top of the window
      aw_send(32'h8000_7FF8, 8'd1, 4'd7, o); ok &= o;
      w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0, o); ok &= o;
      w_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1, o); ok &= o;
      b_take(rs, id, o); ok &= o;
      total++; if (rs !== 2'b10) begin bad++; $display("FAIL edge_bresp: got %b want 10", rs); end
      ar_send(32'h8000_7FF8, 8'd1, 4'd8, o); ok &= o;
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if ({d, rs, l} !== {64'h5555_5555_5555_5555, 2'b00, 1'b0}) begin
         bad++; $display("FAIL edge_beat0: data=%h resp=%b last=%b want 5555555555555555 00 0", d, rs, l);
      end
      r_take(d, rs, l, id, o); ok &= o;
      total++;
      if ({d, rs, l} !== {64'h0, 2'b10, 1'b1}) begin
         bad++; $display("FAIL edge_beat1: data=%h resp=%b last=%b want 0 10 1", d, rs, l);
      end
      total++; if (!ok) begin bad++; $display("FAIL oor_handshake: timeout got 0 want 1"); end
   endtask

   task automatic test_early_wlast();
      bit ok, o; logic [1:0] rs; logic [3:0] id;
      aw_send(32'h8000_0200, 8'd2, 4'd9, ok);
      w_beat(64'h1, 8'hFF, 1'b0, o); ok &= o;
      w_beat(64'h2, 8'hFF, 1'b1, o); ok &= o;
      total++;
      if (wready_o !== 1'b1) begin bad++; $display("FAIL early_wlast_stay: wready %b want 1", wready_o); end
      w_beat(64'h3, 8'hFF, 1'b0, o); ok &= o;
      total++;
      if ({wready_o, bvalid_o} !== 2'b01) begin
         bad++; $display("FAIL early_wlast_leave: wready=%b bvalid=%b want 0 1", wready_o, bvalid_o);
      end
      b_take(rs, id, o); ok &= o;
      total++;
      if ({rs, id} !== {2'b10, 4'd9}) begin
         bad++; $display("FAIL early_wlast_b: resp=%b id=%h want 10 9", rs, id);
      end
      total++; if (!ok) begin bad++; $display("FAIL early_wlast_handshake: timeout got 0 want 1"); end
   endtask

   task automatic test_reset_mid_burst();
      int n; bit stale;
      d_araddr = 32'h8000_0100; d_arlen = 8'd3; d_arid = 4'hA; d_arvalid = 1'b1;
      n = 0;
      while (!d_arready_o && n < 300) begin @(posedge clk); #1; n++; end
      total++;
      if (d_arready_o !== 1'b1) begin bad++; $display("FAIL dly_arready: timeout got 0 want 1"); end
      @(posedge clk); #1;
      d_arvalid = 1'b0;
      total++;
      if ({d_rid_o, d_rlast_o} !== {4'hA, 1'b0}) begin
         bad++; $display("FAIL dly_in_burst: rid=%h rlast=%b want a 0", d_rid_o, d_rlast_o);
      end
      #2; d_rst = 1'b1; #1;
      total++;
      if ({d_arready_o, d_awready_o, d_wready_o, d_rvalid_o, d_bvalid_o, d_rlast_o, d_rresp_o,
           d_bresp_o, d_rid_o, d_bid_o, d_rdata_o} !== '0) begin
         bad++; $display("FAIL dly_async_reset: rvalid=%b rid=%h rdata=%h want all zero",
                         d_rvalid_o, d_rid_o, d_rdata_o);
      end
      @(posedge clk); #1; @(posedge clk); #1;
      d_rst = 1'b0;
      stale = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (d_rvalid_o || d_bvalid_o) stale = 1'b1;
      end
      total++; if (stale) begin bad++; $display("FAIL dly_stale_valid: got 1 want 0"); end
      d_araddr = 32'h7FFF_FFF8; d_arlen = 8'd0; d_arid = 4'h6; d_arvalid = 1'b1;
      n = 0;
      while (!d_arready_o && n < 300) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      d_arvalid = 1'b0; d_rready = 1'b1;
      n = 0;
      while (!d_rvalid_o && n < 300) begin @(posedge clk); #1; n++; end
      total++;
      if ({d_rvalid_o, d_rdata_o, d_rresp_o, d_rlast_o, d_rid_o} !== {1'b1, 64'h0, 2'b10, 1'b1, 4'h6}) begin
         bad++; $display("FAIL dly_fresh_read: valid=%b data=%h resp=%b last=%b id=%h want 1 0 10 1 6",
                         d_rvalid_o, d_rdata_o, d_rresp_o, d_rlast_o, d_rid_o);
      end
      @(posedge clk); #1;
      d_rready = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; d_rst = 1'b1;
      araddr = '0; arlen = '0; arid = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awlen = '0; awid = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      d_araddr = '0; d_arlen = '0; d_arid = '0; d_arvalid = 1'b0; d_rready = 1'b0;
      test_reset();
      test_single();
      test_partial();
      test_burst();
      test_out_of_range();
      test_early_wlast();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
AXI4 slave/responder, the memory-side endpoint for the core's AXI4 master bus arbiter. It services single-beat and INCR burst reads and writes on a 64-bit data bus from an internal SRAM array. An optional LFSR gate inserts pseudo-random ready/valid stalls to stress the master's handshakes in simulation.

Parameters:
ADDR_W, 32, address width
DEPTH, 4096, SRAM depth in 64-bit words; power of two
BASE, 32'h8000_0000, byte address of word 0
DELAY_EN, 0, 1 gates arready_o/awready_o/rvalid_o/bvalid_o with the LFSR bit

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
araddr  in  ADDR_W  read start byte address
arlen  in  8  beats-1
arid  in  4  read ID
arvalid  in  1  AR valid
arready_o  out  1  AR ready
rdata_o  out  64  read data
rid_o  out  4  echoed arid
rlast_o  out  1  final read beat
rresp_o  out  2  00 OKAY, 10 SLVERR
rvalid_o  out  1  R valid
rready  in  1  R ready
awaddr  in  ADDR_W  write start byte address
awlen  in  8  beats-1
awid  in  4  write ID
awvalid  in  1  AW valid
awready_o  out  1  AW ready
wdata  in  64  write data
wstrb  in  8  byte enables
wlast  in  1  final write beat
wvalid  in  1  W valid
wready_o  out  1  W ready
bid_o  out  4  echoed awid
bresp_o  out  2  00 OKAY, 10 SLVERR
bvalid_o  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (async, any state): all outputs 0, both FSMs idle, LFSR=1, counters 0; SRAM contents kept. Mid-burst reset aborts the transaction; no stale rvalid_o/bvalid_o after release.
- gate = DELAY_EN ? lfsr[19] : 1; 20-bit LFSR, shifts every cycle, feedback lfsr[19]^lfsr[18].
- Word index = (addr-BASE)>>3. Beat out of range when addr<BASE or index>=DEPTH. Bursts always INCR: addr+=8 per beat. awburst/arsize/awsize are not ports; full 64-bit lanes, byte selection by wstrb only.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  R_IDLE: arready_o=gate. On arvalid&arready_o, latch addr/len/id, beat=0, go to R_DATA.
  R_DATA: rvalid_o=1 from the cycle after the AR handshake, minimum latency 1. rdata_o = registered mem[index], 0 if out of range. rresp_o=10 per out-of-range beat. rlast_o=(beat==len). rdata_o/rresp_o/rlast_o stay stable while rvalid_o&!rready. With DELAY_EN, rvalid_o is withheld while gate=0 and, once raised, holds until handshake. On handshake: last beat -> R_IDLE, else beat++ and next beat valid next cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  W_IDLE: awready_o=gate. On handshake, latch addr/len/id, beat=0, err=0.
  W_DATA: wready_o=1. Each wvalid handshake writes wdata bytes where wstrb=1 at that edge; out-of-range beat is dropped and sets err. wlast!=(beat==len) sets err. Leave on beat==len regardless of wlast.
  W_RESP: bvalid_o=1 (gated like rvalid_o), bid_o=id, bresp_o=err?10:00. On bready -> W_IDLE.
- Read and write channels are independent and may overlap. Same word written and read-fetched on the same edge: the read returns old data, the write commits.
- W beats before the AW handshake are not accepted (wready_o=0 in W_IDLE).
- arlen=0 / awlen=0 is a single beat with rlast_o / wlast on beat 0.

Decomposition:
- Shared package: AXI resp constants (OKAY=2'b00, SLVERR=2'b10), read/write FSM state enums, LFSR width and taps (shared with the arbiter's delay LFSR).
- One sub-module: axi4_lfsr_gate (20-bit LFSR plus enable mux), reusable by other bus models.

Test Plan:
- Single write awaddr=8000_0008, wdata=1122334455667788, wstrb=FF, then read same address -> bresp 00, rdata_o=1122334455667788, rlast_o=1, rresp_o=00, rid_o=arid.
- Partial write wstrb=0F, wdata=AAAAAAAA_BBBBBBBB over prior 1122334455667788 -> read returns 11223344_BBBBBBBB.
- 4-beat burst write at 8000_0100, arlen=3 read back with rready toggling 1010 -> four beats in order, data stable during stalls, rlast_o only on beat 3.
- Read araddr=7FFF_FFF8 and write to BASE+DEPTH*8 -> rresp_o=10, rdata_o=0; bresp_o=10 and memory unchanged.
- Early wlast on beat 1 of awlen=2 -> three beats accepted, bresp_o=10.
- rst asserted mid read burst with DELAY_EN=1 -> all outputs 0 asynchronously; a fresh read after release completes correctly.
